// File: rtl/resonant_pkg.sv
// Shared types and arithmetic helpers for the multi-channel resonant-system emulator.
// Optional Q-loss emulation is compiled in with the Q_DROP_EN macro.
package resonant_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    HI,
    LO,
    DONE,
    GAP
  } res_state_t;

  function automatic int unsigned sat_sub(input int unsigned a, input int unsigned b);
    return (a > b) ? (a - b) : 0;
  endfunction

  // Pulses per window: scaled reference code clamped to the saturation limit.
  function automatic int unsigned pulse_count(input int unsigned code,
                                              input int unsigned shift,
                                              input int unsigned max_p);
    int unsigned n;
    n = code >> shift;
    return (n > max_p) ? max_p : n;
  endfunction

endpackage

// File: rtl/resonant_ch.sv
// One resonator channel: window FSM, pulse/duration/gap counters, optional Q-drop window counter.
// Q_DROP_EN adds the completed-window counter and the per-window pulse reduction.
module resonant_ch
  import resonant_pkg::*;
#(
  parameter int unsigned BUS_WIDTH      = 10,
  parameter int unsigned PULSE_DURATION = 3,
  parameter int unsigned SCALE_SHIFT    = 3,
  parameter int unsigned MAX_PULSES     = 100,
  parameter int unsigned WIN_GAP        = 4
`ifdef Q_DROP_EN
  ,
  parameter int unsigned DROP_AFTER     = 8,
  parameter int unsigned DROP_PULSES    = 2
`endif
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [BUS_WIDTH-1:0] i_ref_i,
  output logic                 q_o,
  output logic                 ended_o,
  output logic                 busy_o,
  output res_state_t           state_o
);

  localparam int unsigned PCW = $clog2(MAX_PULSES + 1);
  localparam int unsigned DCW = $clog2(PULSE_DURATION + 1);
  localparam int unsigned GCW = $clog2(WIN_GAP + 1);

  res_state_t     state_q, state_d;
  logic [DCW-1:0] dur_q, dur_d;
  logic [PCW-1:0] rem_q, rem_d;
  logic [GCW-1:0] gap_q, gap_d;
  logic [PCW-1:0] n_load;
  int unsigned    n_calc;
  logic           dur_last;

`ifdef Q_DROP_EN
  localparam int unsigned WCW = $clog2(DROP_AFTER + 1);
  logic [WCW-1:0] win_q, win_d;
  logic           drop_on;

  // The window counter parks at DROP_AFTER, which also marks the drop as active for good.
  assign drop_on = (win_q == WCW'(DROP_AFTER));

  always_comb begin
    win_d = win_q;
    if (state_q == DONE && !drop_on) begin
      win_d = win_q + 1'b1;
    end
  end
`endif

  always_comb begin
    n_calc = pulse_count(32'(i_ref_i), SCALE_SHIFT, MAX_PULSES);
`ifdef Q_DROP_EN
    if (drop_on) begin
      n_calc = sat_sub(n_calc, DROP_PULSES);
    end
`endif
    n_load = PCW'(n_calc);
  end

  assign dur_last = (dur_q == DCW'(PULSE_DURATION - 1));

  // start is a level enable: dropping it inside LOAD/HI/LO abandons the window without a strobe.
  always_comb begin
    state_d = state_q;
    dur_d   = dur_q;
    rem_d   = rem_q;
    gap_d   = gap_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        dur_d = '0;
        if (!start_i) begin
          state_d = IDLE;
        end else begin
          rem_d   = n_load;
          state_d = (n_load == '0) ? DONE : HI;
        end
      end
      HI: begin
        if (!start_i) begin
          state_d = IDLE;
        end else if (dur_last) begin
          dur_d   = '0;
          state_d = LO;
        end else begin
          dur_d = dur_q + 1'b1;
        end
      end
      LO: begin
        if (!start_i) begin
          state_d = IDLE;
        end else if (dur_last) begin
          dur_d   = '0;
          rem_d   = rem_q - 1'b1;
          state_d = (rem_q == PCW'(1)) ? DONE : HI;
        end else begin
          dur_d = dur_q + 1'b1;
        end
      end
      DONE: begin
        gap_d   = '0;
        state_d = GAP;
      end
      GAP: begin
        if (gap_q == GCW'(WIN_GAP - 1)) begin
          gap_d   = '0;
          state_d = IDLE;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dur_q   <= '0;
      rem_q   <= '0;
      gap_q   <= '0;
`ifdef Q_DROP_EN
      win_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      dur_q   <= dur_d;
      rem_q   <= rem_d;
      gap_q   <= gap_d;
`ifdef Q_DROP_EN
      win_q   <= win_d;
`endif
    end
  end

  // Outputs decode the registered state only, so reset clears them immediately.
  assign q_o     = (state_q == HI);
  assign ended_o = (state_q == DONE);
  assign busy_o  = (state_q == LOAD) || (state_q == HI) || (state_q == LO) || (state_q == DONE);
  assign state_o = state_q;

endmodule

// File: rtl/resonant_sys_mc.sv
// Multi-channel resonant-system emulator: N_CH independent pulse-train channels sharing start.
// Define Q_DROP_EN to enable the Q-loss emulation in every channel.
module resonant_sys_mc
  import resonant_pkg::*;
#(
  parameter int unsigned N_CH           = 2,
  parameter int unsigned BUS_WIDTH      = 10,
  parameter int unsigned PULSE_DURATION = 3,
  parameter int unsigned SCALE_SHIFT    = 3,
  parameter int unsigned MAX_PULSES     = 100,
  parameter int unsigned WIN_GAP        = 4
`ifdef Q_DROP_EN
  ,
  parameter int unsigned DROP_AFTER     = 8,
  parameter int unsigned DROP_PULSES    = 2
`endif
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [N_CH*BUS_WIDTH-1:0] i_ref,
  output logic [N_CH-1:0]           q_serialized,
  output logic [N_CH-1:0]           pulses_ended,
  output logic [N_CH-1:0]           busy,
  output logic [3*N_CH-1:0]         state_dbg_o
);

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    res_state_t ch_state;

    resonant_ch #(
      .BUS_WIDTH      (BUS_WIDTH),
      .PULSE_DURATION (PULSE_DURATION),
      .SCALE_SHIFT    (SCALE_SHIFT),
      .MAX_PULSES     (MAX_PULSES),
      .WIN_GAP        (WIN_GAP)
`ifdef Q_DROP_EN
      ,
      .DROP_AFTER     (DROP_AFTER),
      .DROP_PULSES    (DROP_PULSES)
`endif
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .start_i (start),
      .i_ref_i (i_ref[c*BUS_WIDTH +: BUS_WIDTH]),
      .q_o     (q_serialized[c]),
      .ended_o (pulses_ended[c]),
      .busy_o  (busy[c]),
      .state_o (ch_state)
    );

    assign state_dbg_o[c*3 +: 3] = ch_state;
  end

endmodule
